// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: OUT/IN/DIR/EDGE registers, own address decode, single-cycle ack.
// Optional build macro WB_GPIO_IRQ_EN adds the MASK register and the edge interrupt.
module wb_gpio_bank #(
  parameter int                AWIDTH  = 2,
  parameter logic [AWIDTH-1:0] ADDR    = 2'b01,
  parameter int                NGPIO   = 8,
  parameter logic [NGPIO-1:0]  OUT_RST = '0
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [31:0]      wb_adr,
  input  logic [31:0]      wb_dat,
  input  logic [3:0]       wb_sel,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic [31:0]      wb_rdt,
  output logic             wb_ack,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             state_r;
  logic               hit_s;
  logic [2:0]         off_s;
  logic               wr_s;
  logic [31:0]        lane_s;
  logic [NGPIO-1:0]   wmask_s;
  logic [NGPIO-1:0]   wdat_s;
  logic [NGPIO-1:0]   edge_clr_s;
  logic [NGPIO-1:0]   rise_s;
  logic [NGPIO-1:0]   out_r;
  logic [NGPIO-1:0]   dir_r;
  logic [NGPIO-1:0]   edge_r;
  logic [NGPIO-1:0]   meta_r;
  logic [NGPIO-1:0]   sync_r;
  logic [NGPIO-1:0]   prev_r;
  logic [31:0]        rd_mux_s;
  logic [31:0]        wb_rdt_r;
  logic               wb_ack_r;
  logic               unused_s;

  assign hit_s    = wb_cyc && (wb_adr[31:32-AWIDTH] == ADDR);
  assign off_s    = wb_adr[4:2];
  assign rise_s   = sync_r & ~prev_r;
  assign unused_s = ^{wb_adr, wb_dat, wb_sel, lane_s};

  // Write strobe and per-bit lane mask derived from the byte enables
  always_comb begin
    lane_s     = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    wmask_s    = lane_s[NGPIO-1:0];
    wdat_s     = wb_dat[NGPIO-1:0];
    wr_s       = (state_r == ST_ACK) && wb_we;
    edge_clr_s = (wr_s && (off_s == 3'd3)) ? (wmask_s & wdat_s) : '0;
  end

  // OUT and DIR registers
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      out_r <= OUT_RST;
      dir_r <= '0;
    end else if (wr_s) begin
      case (off_s)
        3'd0:    out_r <= (out_r & ~wmask_s) | (wdat_s & wmask_s);
        3'd2:    dir_r <= (dir_r & ~wmask_s) | (wdat_s & wmask_s);
        default: ;
      endcase
    end
  end

  // Input synchroniser and rising-edge capture; a new edge beats a same-cycle clear
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
      edge_r <= '0;
    end else begin
      meta_r <= gpio_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      edge_r <= (edge_r & ~edge_clr_s) | rise_s;
    end
  end

`ifdef WB_GPIO_IRQ_EN
  logic [NGPIO-1:0] mask_r;
  logic             irq_r;

  // Interrupt mask register and registered level interrupt
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      mask_r <= '0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_s && (off_s == 3'd4)) begin
        mask_r <= (mask_r & ~wmask_s) | (wdat_s & wmask_s);
      end else begin
        mask_r <= mask_r;
      end
      irq_r <= |(edge_r & mask_r);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // Register read multiplexer, unused bits and offsets read zero
  always_comb begin
    rd_mux_s = '0;
    case (off_s)
      3'd0:    rd_mux_s[NGPIO-1:0] = out_r;
      3'd1:    rd_mux_s[NGPIO-1:0] = sync_r;
      3'd2:    rd_mux_s[NGPIO-1:0] = dir_r;
      3'd3:    rd_mux_s[NGPIO-1:0] = edge_r;
`ifdef WB_GPIO_IRQ_EN
      3'd4:    rd_mux_s[NGPIO-1:0] = mask_r;
`endif
      default: rd_mux_s = '0;
    endcase
  end

  // Bus handshake: one ack per hit, then wait for the master to release the cycle
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r  <= ST_IDLE;
      wb_ack_r <= 1'b0;
      wb_rdt_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            state_r  <= ST_ACK;
            wb_ack_r <= 1'b1;
            wb_rdt_r <= rd_mux_s;
          end else begin
            state_r  <= ST_IDLE;
            wb_ack_r <= 1'b0;
            wb_rdt_r <= 32'h0000_0000;
          end
        end
        ST_ACK: begin
          state_r  <= ST_WAIT;
          wb_ack_r <= 1'b0;
          wb_rdt_r <= 32'h0000_0000;
        end
        ST_WAIT: begin
          state_r  <= hit_s ? ST_WAIT : ST_IDLE;
          wb_ack_r <= 1'b0;
          wb_rdt_r <= 32'h0000_0000;
        end
        default: begin
          state_r  <= ST_IDLE;
          wb_ack_r <= 1'b0;
          wb_rdt_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign wb_ack   = wb_ack_r;
  assign wb_rdt   = wb_rdt_r;
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;

endmodule
